tl_link_channel: RTL and testbench
==================================

Name: tl_link_channel

Overview:
- Parametrised bidirectional link model between two transaction-layer endpoints (Device A, Device B), replacing direct back-to-back TLP wiring.
- Per direction (A2B, B2A): valid/ready handshake, SOP/EOP framing, configurable link delay and bounded buffering.
- Framing check with drop-and-flag; received-packet counters for the bench and the top level.

Parameters:
- BUS_WIDTH, 128, TLP beat width in bits.
- DEPTH, 4, max beats held per direction (delay pipeline plus FIFO); must be ≥1.
- LINK_DELAY, 2, extra cycles a beat spends in flight before it is enqueued; 0 allowed.
- CNT_W, 16, width of packet counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- a_tx_tlp  in  BUS_WIDTH  beat from A.
- a_tx_sop  in  1  first beat of TLP.
- a_tx_eop  in  1  last beat of TLP.
- a_tx_valid  in  1  A beat valid.
- a_tx_ready  out  1  channel accepts A beat.
- b_rx_tlp  out  BUS_WIDTH  beat to B.
- b_rx_sop  out  1  first beat to B.
- b_rx_eop  out  1  last beat to B.
- b_rx_valid  out  1  beat to B valid.
- b_rx_ready  in  1  B accepts beat.
- b_tx_tlp, b_tx_sop, b_tx_eop, b_tx_valid, b_tx_ready: as a_tx_*, from B.
- a_rx_tlp, a_rx_sop, a_rx_eop, a_rx_valid, a_rx_ready: as b_rx_*, to A.
- a2b_level  out  $clog2(DEPTH+1)  A2B occupancy (in flight plus queued).
- b2a_level  out  $clog2(DEPTH+1)  B2A occupancy.
- a2b_pkt_cnt  out  CNT_W  EOP beats delivered to B.
- b2a_pkt_cnt  out  CNT_W  EOP beats delivered to A.
- a2b_frm_err  out  1  sticky framing error, A2B.
- b2a_frm_err  out  1  sticky framing error, B2A.

Behaviour:
- One clock; reset is synchronous and active-high: rst sampled high on a clk rising edge resets all state.
- The two directions are identical and fully independent. Described below for A2B.
- Reset values:
  - *_rx_valid = 0; *_rx_tlp/sop/eop = 0.
  - levels = 0; pkt counters = 0; frm_err = 0.
  - *_tx_ready = 1 from the first cycle after reset.
  - Framing state = IDLE.
- Accept:
  - a_tx_ready = (a2b_level < DEPTH). It is a function of registered state only; no combinational path from b_rx_ready.
  - A beat is accepted when a_tx_valid && a_tx_ready.
- Occupancy:
  - a2b_level increments on each accept and decrements on each delivery (b_rx_valid && b_rx_ready).
  - Simultaneous accept and delivery leaves the level unchanged.
  - A full channel never accepts, even if a delivery occurs in the same cycle.
- Delay:
  - An accepted beat passes through LINK_DELAY register stages, then enters the FIFO.
  - The earliest b_rx_valid is LINK_DELAY+1 cycles after the accept edge.
  - Beats are delivered in order; back-to-back accepts are delivered back-to-back when b_rx_ready=1.
- Delivery: b_rx_* shows the FIFO head; once asserted, valid and data are held stable until b_rx_ready.
- Framing FSM, evaluated on accepted beats only:
  - IDLE, sop=1, eop=1: store beat, stay IDLE.
  - IDLE, sop=1, eop=0: store beat, go to IN_PKT.
  - IDLE, sop=0: drop beat (still consumes the handshake, no level change), set a2b_frm_err.
  - IN_PKT, sop=0, eop=0: store beat.
  - IN_PKT, sop=0, eop=1: store beat, go to IDLE.
  - IN_PKT, sop=1: drop beat, set a2b_frm_err, stay IN_PKT.
  - a2b_frm_err is sticky; only rst clears it.
- Packet count: a2b_pkt_cnt increments on each delivered beat with eop=1 and wraps 2^CNT_W−1 → 0.
- Reset mid-packet or mid-flight: all in-flight and queued beats are discarded, b_rx_valid is 0 the next cycle, and framing returns to IDLE.

Test Plan:
- Single-beat TLP 0x1234 (sop=eop=1) from A, LINK_DELAY=2, b_rx_ready=1: accepted at edge 0; b_rx_valid=1 with tlp=0x1234 at edge 3; a2b_pkt_cnt=1 after delivery; level returns to 0.
- b_rx_ready=0, A streams 4-beat TLP, DEPTH=4: all 4 accepted, a2b_level=4, a_tx_ready=0. Raise b_rx_ready: 4 beats delivered in order with sop on beat 0 and eop on beat 3; a_tx_ready=1 one cycle after the first delivery.
- Full channel with valid on both sides in the same cycle: no accept, level 4→3, then accept next cycle with level staying at 3.
- Beat with sop=0 while IDLE: beat dropped, a2b_frm_err=1, level unchanged. A following valid 1-beat TLP is delivered normally and the flag stays 1.
- Concurrent A2B and B2A 3-beat TLPs: each direction is delivered intact, and a2b_pkt_cnt = b2a_pkt_cnt = 1.
- rst asserted while 2 beats are in flight: next cycle levels=0, rx_valid=0, frm_err=0; a new TLP is delivered with normal latency.

Source files
------------

// File: rtl/tl_link_channel.sv
// Bidirectional link model between two transaction-layer endpoints.
// Each direction has a delay line, a bounded FIFO, framing checks and a packet counter.

module tl_link_dir #(
  parameter int BUS_WIDTH  = 128,
  parameter int DEPTH      = 4,
  parameter int LINK_DELAY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_WIDTH-1:0]         tx_tlp,
  input  logic                         tx_sop,
  input  logic                         tx_eop,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [BUS_WIDTH-1:0]         rx_tlp,
  output logic                         rx_sop,
  output logic                         rx_eop,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             pkt_cnt,
  output logic                         frm_err
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = BUS_WIDTH + 2;
  localparam logic IDLE   = 1'b0;
  localparam logic IN_PKT = 1'b1;

  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [BEAT_W-1:0] mem [DEPTH];
  logic              frm_state;
  logic              frm_err_q;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic              accept;
  logic              frame_ok;
  logic              store;
  logic              deliver;
  logic              enq_valid;
  logic [BEAT_W-1:0] enq_beat;
  logic [BEAT_W-1:0] head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Level counts in-flight plus queued beats, so the FIFO itself can never overflow.
  assign tx_ready = (level_q < LVL_W'(DEPTH));
  assign accept   = tx_valid && tx_ready;
  assign frame_ok = (frm_state == IDLE) ? tx_sop : !tx_sop;
  assign store    = accept && frame_ok;
  assign rx_valid = (fifo_cnt != '0);
  assign deliver  = rx_valid && rx_ready;
  assign head     = rx_valid ? mem[rd_ptr] : '0;
  assign rx_tlp   = head[BEAT_W-1:2];
  assign rx_sop   = head[1];
  assign rx_eop   = head[0];
  assign level    = level_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign frm_err  = frm_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_state <= IDLE;
      frm_err_q <= 1'b0;
    end else if (accept) begin
      if (!frame_ok)
        frm_err_q <= 1'b1;
      else if (frm_state == IDLE && !tx_eop)
        frm_state <= IN_PKT;
      else if (frm_state == IN_PKT && tx_eop)
        frm_state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      case ({store, deliver})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  generate
    if (LINK_DELAY == 0) begin : g_no_delay
      assign enq_valid = store;
      assign enq_beat  = {tx_tlp, tx_sop, tx_eop};
    end else begin : g_delay
      logic [LINK_DELAY-1:0] dly_valid;
      logic [BEAT_W-1:0]     dly_beat [LINK_DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          dly_valid <= '0;
        end else begin
          dly_valid[0] <= store;
          for (int i = 1; i < LINK_DELAY; i++)
            dly_valid[i] <= dly_valid[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dly_beat[0] <= {tx_tlp, tx_sop, tx_eop};
        for (int i = 1; i < LINK_DELAY; i++)
          dly_beat[i] <= dly_beat[i-1];
      end

      assign enq_valid = dly_valid[LINK_DELAY-1];
      assign enq_beat  = dly_beat[LINK_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq_valid) wr_ptr <= next_ptr(wr_ptr);
      if (deliver)   rd_ptr <= next_ptr(rd_ptr);
      case ({enq_valid, deliver})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage is not reset; the valid count gates every read, so stale contents never reach rx_*.
  always_ff @(posedge clk) begin
    if (enq_valid) mem[wr_ptr] <= enq_beat;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pkt_cnt_q <= '0;
    else if (deliver && rx_eop)
      pkt_cnt_q <= pkt_cnt_q + 1'b1;
  end

endmodule

module tl_link_channel #(
  parameter int BUS_WIDTH  = 128,
  parameter int DEPTH      = 4,
  parameter int LINK_DELAY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_WIDTH-1:0]       a_tx_tlp,
  input  logic                       a_tx_sop,
  input  logic                       a_tx_eop,
  input  logic                       a_tx_valid,
  output logic                       a_tx_ready,
  output logic [BUS_WIDTH-1:0]       b_rx_tlp,
  output logic                       b_rx_sop,
  output logic                       b_rx_eop,
  output logic                       b_rx_valid,
  input  logic                       b_rx_ready,
  input  logic [BUS_WIDTH-1:0]       b_tx_tlp,
  input  logic                       b_tx_sop,
  input  logic                       b_tx_eop,
  input  logic                       b_tx_valid,
  output logic                       b_tx_ready,
  output logic [BUS_WIDTH-1:0]       a_rx_tlp,
  output logic                       a_rx_sop,
  output logic                       a_rx_eop,
  output logic                       a_rx_valid,
  input  logic                       a_rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] a2b_level,
  output logic [$clog2(DEPTH+1)-1:0] b2a_level,
  output logic [CNT_W-1:0]           a2b_pkt_cnt,
  output logic [CNT_W-1:0]           b2a_pkt_cnt,
  output logic                       a2b_frm_err,
  output logic                       b2a_frm_err
);

  tl_link_dir #(
    .BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH), .LINK_DELAY(LINK_DELAY), .CNT_W(CNT_W)
  ) u_a2b (
    .clk(clk), .rst(rst),
    .tx_tlp(a_tx_tlp), .tx_sop(a_tx_sop), .tx_eop(a_tx_eop),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_tlp(b_rx_tlp), .rx_sop(b_rx_sop), .rx_eop(b_rx_eop),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .level(a2b_level), .pkt_cnt(a2b_pkt_cnt), .frm_err(a2b_frm_err)
  );

  tl_link_dir #(
    .BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH), .LINK_DELAY(LINK_DELAY), .CNT_W(CNT_W)
  ) u_b2a (
    .clk(clk), .rst(rst),
    .tx_tlp(b_tx_tlp), .tx_sop(b_tx_sop), .tx_eop(b_tx_eop),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_tlp(a_rx_tlp), .rx_sop(a_rx_sop), .rx_eop(a_rx_eop),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .level(b2a_level), .pkt_cnt(b2a_pkt_cnt), .frm_err(b2a_frm_err)
  );

endmodule

// File: tb/tb_tl_link_channel.sv
// Directed bench for tl_link_channel: per-cycle A2B vector table plus reset and
// concurrent-traffic sequences.

module tb_tl_link_channel;

  localparam int BW = 128;
  localparam int DEPTH = 4;
  localparam int LD = 2;
  localparam int CW = 16;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] a_tx_tlp, b_rx_tlp, b_tx_tlp, a_rx_tlp;
  logic          a_tx_sop, a_tx_eop, a_tx_valid, a_tx_ready;
  logic          b_rx_sop, b_rx_eop, b_rx_valid, b_rx_ready;
  logic          b_tx_sop, b_tx_eop, b_tx_valid, b_tx_ready;
  logic          a_rx_sop, a_rx_eop, a_rx_valid, a_rx_ready;
  logic [LW-1:0] a2b_level, b2a_level;
  logic [CW-1:0] a2b_pkt_cnt, b2a_pkt_cnt;
  logic          a2b_frm_err, b2a_frm_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tl_link_channel #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .LINK_DELAY(LD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_tx_tlp(a_tx_tlp), .a_tx_sop(a_tx_sop), .a_tx_eop(a_tx_eop),
    .a_tx_valid(a_tx_valid), .a_tx_ready(a_tx_ready),
    .b_rx_tlp(b_rx_tlp), .b_rx_sop(b_rx_sop), .b_rx_eop(b_rx_eop),
    .b_rx_valid(b_rx_valid), .b_rx_ready(b_rx_ready),
    .b_tx_tlp(b_tx_tlp), .b_tx_sop(b_tx_sop), .b_tx_eop(b_tx_eop),
    .b_tx_valid(b_tx_valid), .b_tx_ready(b_tx_ready),
    .a_rx_tlp(a_rx_tlp), .a_rx_sop(a_rx_sop), .a_rx_eop(a_rx_eop),
    .a_rx_valid(a_rx_valid), .a_rx_ready(a_rx_ready),
    .a2b_level(a2b_level), .b2a_level(b2a_level),
    .a2b_pkt_cnt(a2b_pkt_cnt), .b2a_pkt_cnt(b2a_pkt_cnt),
    .a2b_frm_err(a2b_frm_err), .b2a_frm_err(b2a_frm_err)
  );

  typedef struct {
    logic        av, as, ae;
    logic [15:0] at;
    logic        br;
    logic        e_ready;
    logic [2:0]  e_level;
    logic        e_valid;
    logic [15:0] e_tlp;
    logic        e_sop, e_eop;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tv [27];

  function automatic vec_t row(input logic av, as, ae, input logic [15:0] at, input logic br,
                               input logic er, input logic [2:0] el, input logic ev,
                               input logic [15:0] et, input logic es, ee,
                               input logic [15:0] ec, input logic eerr);
    vec_t v;
    v.av = av; v.as = as; v.ae = ae; v.at = at; v.br = br;
    v.e_ready = er; v.e_level = el; v.e_valid = ev; v.e_tlp = et;
    v.e_sop = es; v.e_eop = ee; v.e_cnt = ec; v.e_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_tx_valid = 0; a_tx_sop = 0; a_tx_eop = 0; a_tx_tlp = '0;
    b_tx_valid = 0; b_tx_sop = 0; b_tx_eop = 0; b_tx_tlp = '0;
  endtask

  logic [BW+1:0] qa[$];
  logic [BW+1:0] qb[$];
  logic [BW+1:0] exp_beat;

  initial begin
    // Inputs for row i; expectations are the state before row i's edge.
    tv[0]  = row(1,1,1,16'h1234,1, 1,0,0,16'h0,0,0, 0,0);
    tv[1]  = row(0,0,0,16'h0,1,    1,1,0,16'h0,0,0, 0,0);
    tv[2]  = row(0,0,0,16'h0,1,    1,1,0,16'h0,0,0, 0,0);
    tv[3]  = row(0,0,0,16'h0,1,    1,1,1,16'h1234,1,1, 0,0);
    tv[4]  = row(0,0,0,16'h0,1,    1,0,0,16'h0,0,0, 1,0);
    tv[5]  = row(1,1,0,16'h00A0,0, 1,0,0,16'h0,0,0, 1,0);
    tv[6]  = row(1,0,0,16'h00A1,0, 1,1,0,16'h0,0,0, 1,0);
    tv[7]  = row(1,0,0,16'h00A2,0, 1,2,0,16'h0,0,0, 1,0);
    tv[8]  = row(1,0,1,16'h00A3,0, 1,3,1,16'h00A0,1,0, 1,0);
    tv[9]  = row(0,0,0,16'h0,0,    0,4,1,16'h00A0,1,0, 1,0);
    tv[10] = row(1,1,1,16'h00B0,1, 0,4,1,16'h00A0,1,0, 1,0);
    tv[11] = row(1,1,1,16'h00B0,1, 1,3,1,16'h00A1,0,0, 1,0);
    tv[12] = row(0,0,0,16'h0,1,    1,3,1,16'h00A2,0,0, 1,0);
    tv[13] = row(0,0,0,16'h0,1,    1,2,1,16'h00A3,0,1, 1,0);
    tv[14] = row(0,0,0,16'h0,1,    1,1,1,16'h00B0,1,1, 2,0);
    tv[15] = row(1,0,1,16'h00E0,1, 1,0,0,16'h0,0,0, 3,0);
    tv[16] = row(1,1,1,16'h00C0,1, 1,0,0,16'h0,0,0, 3,1);
    tv[17] = row(0,0,0,16'h0,1,    1,1,0,16'h0,0,0, 3,1);
    tv[18] = row(0,0,0,16'h0,1,    1,1,0,16'h0,0,0, 3,1);
    tv[19] = row(0,0,0,16'h0,1,    1,1,1,16'h00C0,1,1, 3,1);
    tv[20] = row(1,1,0,16'h00D0,1, 1,0,0,16'h0,0,0, 4,1);
    tv[21] = row(1,1,0,16'h00D1,1, 1,1,0,16'h0,0,0, 4,1);
    tv[22] = row(1,0,1,16'h00D2,1, 1,1,0,16'h0,0,0, 4,1);
    tv[23] = row(0,0,0,16'h0,1,    1,2,1,16'h00D0,1,0, 4,1);
    tv[24] = row(0,0,0,16'h0,1,    1,1,0,16'h0,0,0, 4,1);
    tv[25] = row(0,0,0,16'h0,1,    1,1,1,16'h00D2,0,1, 4,1);
    tv[26] = row(0,0,0,16'h0,1,    1,0,0,16'h0,0,0, 5,1);

    idle_inputs();
    b_rx_ready = 1; a_rx_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("reset b_rx_tlp", b_rx_tlp, '0);
    check("reset b_rx_sop_eop", {b_rx_sop, b_rx_eop}, 2'b00);
    check("reset a_rx_valid", a_rx_valid, 0);
    check("reset b_tx_ready", b_tx_ready, 1);
    check("reset b2a_frm_err", b2a_frm_err, 0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d a_tx_ready", i), a_tx_ready, tv[i].e_ready);
      check($sformatf("vec%0d a2b_level", i), a2b_level, tv[i].e_level);
      check($sformatf("vec%0d b_rx_valid", i), b_rx_valid, tv[i].e_valid);
      if (tv[i].e_valid) begin
        check($sformatf("vec%0d b_rx_tlp", i), b_rx_tlp, tv[i].e_tlp);
        check($sformatf("vec%0d b_rx_sop_eop", i), {b_rx_sop, b_rx_eop}, {tv[i].e_sop, tv[i].e_eop});
      end
      check($sformatf("vec%0d a2b_pkt_cnt", i), a2b_pkt_cnt, tv[i].e_cnt);
      check($sformatf("vec%0d a2b_frm_err", i), a2b_frm_err, tv[i].e_err);
      check($sformatf("vec%0d b2a idle", i), {b2a_level, a_rx_valid}, '0);
      a_tx_valid = tv[i].av; a_tx_sop = tv[i].as; a_tx_eop = tv[i].ae;
      a_tx_tlp = BW'(tv[i].at); b_rx_ready = tv[i].br;
    end

    // Reset with two beats of an open packet still in flight.
    @(negedge clk);
    a_tx_valid = 1; a_tx_sop = 1; a_tx_eop = 0; a_tx_tlp = BW'(16'h0051);
    @(negedge clk);
    a_tx_sop = 0; a_tx_tlp = BW'(16'h0052);
    @(negedge clk);
    idle_inputs();
    check("pre-reset a2b_level", a2b_level, 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst mid-flight a2b_level", a2b_level, 0);
    check("rst mid-flight b_rx_valid", b_rx_valid, 0);
    check("rst mid-flight a2b_frm_err", a2b_frm_err, 0);
    check("rst mid-flight a2b_pkt_cnt", a2b_pkt_cnt, 0);
    check("rst mid-flight a_tx_ready", a_tx_ready, 1);
    @(negedge clk);
    a_tx_valid = 1; a_tx_sop = 1; a_tx_eop = 1; a_tx_tlp = BW'(16'h0077);
    @(negedge clk);
    idle_inputs();
    check("post-rst lat1 b_rx_valid", b_rx_valid, 0);
    @(negedge clk);
    check("post-rst lat2 b_rx_valid", b_rx_valid, 0);
    @(negedge clk);
    check("post-rst lat3 b_rx_valid", b_rx_valid, 1);
    check("post-rst b_rx_tlp", b_rx_tlp, BW'(16'h0077));
    @(negedge clk);
    check("post-rst a2b_pkt_cnt", a2b_pkt_cnt, 1);
    check("post-rst a2b_frm_err", a2b_frm_err, 0);
    check("post-rst a2b_level", a2b_level, 0);

    // Concurrent 3-beat TLPs in both directions.
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (b_rx_valid) qa.push_back({b_rx_sop, b_rx_eop, b_rx_tlp});
      if (a_rx_valid) qb.push_back({a_rx_sop, a_rx_eop, a_rx_tlp});
      if (c < 3) begin
        a_tx_valid = 1; a_tx_sop = (c == 0); a_tx_eop = (c == 2); a_tx_tlp = BW'(16'h0A10 + c);
        b_tx_valid = 1; b_tx_sop = (c == 0); b_tx_eop = (c == 2); b_tx_tlp = BW'(16'h0B10 + c);
      end else begin
        idle_inputs();
      end
    end
    check("concurrent a2b beats", qa.size(), 3);
    check("concurrent b2a beats", qb.size(), 3);
    for (int k = 0; k < 3; k++) begin
      exp_beat = {k == 0, k == 2, BW'(16'h0A10 + k)};
      if (k < qa.size()) check($sformatf("concurrent a2b beat%0d", k), BW'(qa[k]), BW'(exp_beat));
      if (k < qa.size()) check($sformatf("concurrent a2b frame%0d", k), qa[k][BW+1:BW], exp_beat[BW+1:BW]);
      exp_beat = {k == 0, k == 2, BW'(16'h0B10 + k)};
      if (k < qb.size()) check($sformatf("concurrent b2a beat%0d", k), BW'(qb[k]), BW'(exp_beat));
      if (k < qb.size()) check($sformatf("concurrent b2a frame%0d", k), qb[k][BW+1:BW], exp_beat[BW+1:BW]);
    end
    check("concurrent a2b_pkt_cnt", a2b_pkt_cnt, 1);
    check("concurrent b2a_pkt_cnt", b2a_pkt_cnt, 1);
    check("concurrent levels", {a2b_level, b2a_level}, '0);
    check("concurrent frm_err", {a2b_frm_err, b2a_frm_err}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
